lod_shift_offset_gen: RTL and testbench

//  Upstream stage of the log-offset LUT in the 8b fractional PE datapath.
//  - Accepts a stream of unsigned fraction operands and finds the leading one.
//  - Emits the 4-bit shift_offset that indexes the log-offset LUT, plus the left-normalised operand and a zero flag.
//  - Two-stage valid/ready pipeline with full throughput and backpressure.

---
 rtl/lod_shift_offset_gen.sv | 91 +++++++++
 tb/tb_lod_shift_offset_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lod_shift_offset_gen.sv
// rtl/lod_shift_offset_gen.sv - leading-one detector producing log-offset LUT index
// Two-stage valid/ready pipeline: S1 holds the operand, S2 holds LZC-derived results.
module lod_shift_offset_gen #(
  parameter int DATA_W = 16,
  parameter int OFF_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OFF_W-1:0]  shift_offset,
  output logic [DATA_W-1:0] norm_data,
  output logic              zero_flag
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s2_valid;
  logic [OFF_W-1:0]  s2_off;
  logic [DATA_W-1:0] s2_norm;
  logic              s2_zero;

  logic              s1_adv;
  logic              s2_adv;

  logic [4:0]        lzc;
  logic              found;
  logic              s1_zero;
  logic [OFF_W-1:0]  off_next;
  logic [DATA_W-1:0] norm_next;

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // Leading-zero count scanning from the MSB; reaches DATA_W for an all-zero operand.
  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (s1_data[i]) found = 1'b1;
        else            lzc   = lzc + 5'd1;
      end
    end
  end

  always_comb begin
    s1_zero   = ~found;
    off_next  = '1;
    norm_next = '0;
    if (!s1_zero) begin
      off_next  = (lzc > 5'd15) ? OFF_W'(15) : OFF_W'(lzc);
      norm_next = s1_data << lzc;
    end
  end

  // Flush drops valids on the next edge regardless of stalls or a concurrent input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_off   <= '0;
      s2_norm  <= '0;
      s2_zero  <= 1'b0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= in_valid;
      if (s1_adv)      s1_data  <= in_data;

      if (flush)       s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv) begin
        s2_off  <= off_next;
        s2_norm <= norm_next;
        s2_zero <= s1_zero;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign shift_offset = s2_off;
  assign norm_data    = s2_norm;
  assign zero_flag    = s2_zero;

endmodule

// File: tb/tb_lod_shift_offset_gen.sv
// tb/tb_lod_shift_offset_gen.sv - randomized and directed bench with a queue-based LZC model
module tb_lod_shift_offset_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  shift_offset;
  logic [15:0] norm_data;
  logic        zero_flag;

  logic        in8_valid = 1'b0;
  logic        in8_ready;
  logic [7:0]  in8_data = '0;
  logic        out8_valid;
  logic        out8_ready = 1'b1;
  logic        flush8 = 1'b0;
  logic [3:0]  shift8;
  logic [7:0]  norm8;
  logic        zero8;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  logic [20:0] q[$];
  logic        prev_stall = 1'b0;
  logic [20:0] prev_out = '0;

  always #5 clk = ~clk;

  lod_shift_offset_gen #(.DATA_W(16), .OFF_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .shift_offset(shift_offset), .norm_data(norm_data), .zero_flag(zero_flag)
  );

  lod_shift_offset_gen #(.DATA_W(8), .OFF_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(in8_valid), .in_ready(in8_ready),
    .in_data(in8_data), .out_valid(out8_valid), .out_ready(out8_ready),
    .shift_offset(shift8), .norm_data(norm8), .zero_flag(zero8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result packed as {zero_flag, shift_offset, norm_data}; normalisation by repeated doubling.
  function automatic logic [20:0] model(input logic [15:0] d, input int w);
    int n;
    int lz;
    n  = int'(d);
    lz = 0;
    if (d == 16'h0) return {1'b1, 4'hF, 16'h0};
    while (n < (1 << (w - 1))) begin
      n  = n * 2;
      lz = lz + 1;
    end
    return {1'b0, 4'((lz > 15) ? 15 : lz), 16'(n)};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", {zero_flag, shift_offset, norm_data}, prev_out);
      end
      check("in_ready_rule", in_ready, (q.size() < 2) || out_ready);
      if (out_valid && out_ready) begin
        check("no_duplicate", q.size() > 0, 1);
        if (q.size() > 0) check("result", {zero_flag, shift_offset, norm_data}, q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        q.push_back(model(in_data, 16));
        accepted++;
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_out   = {zero_flag, shift_offset, norm_data};
    end
  end

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ops1 [4];
    logic [20:0] exp1 [4];
    int cyc;
    ops1[0] = 16'h8000; ops1[1] = 16'h0001; ops1[2] = 16'h00F0; ops1[3] = 16'h0000;
    exp1[0] = {1'b0, 4'd0, 16'h8000};
    exp1[1] = {1'b0, 4'd15, 16'h8000};
    exp1[2] = {1'b0, 4'd8, 16'hF000};
    exp1[3] = {1'b1, 4'hF, 16'h0000};

    check("model_pin_f0", model(16'h00F0, 16), {1'b0, 4'd8, 16'hF000});
    check("model_pin_1_w8", model(16'h0001, 8), {1'b0, 4'd7, 16'h0080});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {zero_flag, shift_offset, norm_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);

    // Directed stream with out_ready high: results two cycles after the transfer
    drain();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin in_valid = 1'b1; in_data = ops1[i]; end
      else in_valid = 1'b0;
      if (i >= 2) begin
        @(negedge clk);
        check("t1_valid", out_valid, 1);
        check("t1_result", {zero_flag, shift_offset, norm_data}, exp1[i-2]);
      end
    end

    // Backpressure: two operands buffered, third refused until out_ready returns
    drain();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h4000;
    @(negedge clk); check("t2_ready_a", in_ready, 1);
    @(posedge clk); #1; in_data = 16'h2000;
    @(negedge clk); check("t2_ready_b", in_ready, 1); check("t2_nvalid", out_valid, 0);
    @(posedge clk); #1; in_data = 16'h1000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_full", in_ready, 0);
      check("t2_hold", {out_valid, shift_offset, norm_data}, {1'b1, 4'd1, 16'h8000});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); check("t2_release", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); check("t2_second", {out_valid, shift_offset, norm_data}, {1'b1, 4'd2, 16'h8000});
    @(posedge clk);
    @(negedge clk); check("t2_third", {out_valid, shift_offset, norm_data}, {1'b1, 4'd3, 16'h8000});

    // Flush with two operands in flight and in_valid asserted
    drain();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0800;
    @(posedge clk); #1; in_data = 16'h0400;
    @(posedge clk); #1; in_data = 16'h0010; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); check("t4_flushed", out_valid, 0); check("t4_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0100;
    @(posedge clk); #1; in_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 10);
    check("t4_first_after", {out_valid, zero_flag, shift_offset, norm_data}, {1'b1, 1'b0, 4'd7, 16'h8000});

    // Randomized traffic including occasional flushes
    drain();
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom) >> $urandom_range(0, 16);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      cyc++;
    end
    check("t3_count", accepted >= 1000, 1);
    drain();
    check("t3_no_loss", q.size(), 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0003;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", {out_valid, zero_flag, shift_offset, norm_data}, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready", in_ready, 1);
    check("t5_nvalid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_replay", out_valid, 0);

    // Narrow instance
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in8_valid = (i < 2);
      in8_data  = (i == 0) ? 8'h01 : 8'h00;
      if (i == 2) begin
        @(negedge clk);
        check("t6_one", {out8_valid, zero8, shift8, norm8}, {1'b1, 1'b0, 4'd7, 8'h80});
      end
      if (i == 3) begin
        @(negedge clk);
        check("t6_zero", {out8_valid, zero8, shift8, norm8}, {1'b1, 1'b1, 4'hF, 8'h00});
        check("t6_model", {zero8, shift8, 8'h00, norm8}, model(16'h0000, 8));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
